// File: rtl/clock_pkg.sv
// Shared constants, types and helpers for the BCD clock/alarm block.
package clock_pkg;

    localparam logic [7:0] SEC_MAX  = 8'h59;
    localparam logic [7:0] MIN_MAX  = 8'h59;
    localparam logic [7:0] HR12_MAX = 8'h12;
    localparam logic [7:0] HR12_MIN = 8'h01;
    localparam logic [7:0] HR24_MAX = 8'h23;

    typedef struct packed {
        logic [7:0] hh;
        logic [7:0] mm;
        logic [7:0] ss;
        logic       pm;
    } bcd_time_t;

    // Both nibbles of a two-digit BCD value must be decimal digits.
    function automatic logic bcd_digits_ok(input logic [7:0] v);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
    endfunction

    // Shared by the time-load path and the alarm write path so both reject
    // exactly the same values.
    function automatic logic is_valid_bcd_time(input bcd_time_t t, input logic h24);
        logic ok;
        ok = bcd_digits_ok(t.hh) && bcd_digits_ok(t.mm) && bcd_digits_ok(t.ss)
             && (t.ss <= SEC_MAX) && (t.mm <= MIN_MAX);
        if (h24)
            ok = ok && (t.hh <= HR24_MAX);
        else
            ok = ok && (t.hh >= HR12_MIN) && (t.hh <= HR12_MAX);
        return ok;
    endfunction

    // Decimal increment of a two-digit BCD value; the caller handles the wrap.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD modulo counter (MIN..MAX) with synchronous load and carry out.
module bcd_mod_counter
    import clock_pkg::*;
#(
    parameter logic [7:0] MIN = 8'h00,
    parameter logic [7:0] MAX = 8'h59
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       inc,
    input  logic       ld,
    input  logic [7:0] ld_val,
    output logic [7:0] val,
    output logic       carry
);

    // Carry is combinational so the next stage advances on the same edge.
    assign carry = inc && !ld && (val == MAX);

    // Load has priority over increment; wrap from MAX back to MIN.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            val <= MIN;
        else if (ld)
            val <= ld_val;
        else if (inc)
            val <= (val == MAX) ? MIN : bcd_inc(val);
    end

endmodule

// File: rtl/bcd_clock_alarm.sv
// BCD time-of-day clock with seconds prescaler, 12/24-hour build option,
// validated time load and a sticky, acknowledgeable alarm.
module bcd_clock_alarm
    import clock_pkg::*;
#(
    parameter int TICKS_PER_SEC = 1,
    parameter bit H24           = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ena,
    input  logic       load,
    input  logic [7:0] load_hh,
    input  logic [7:0] load_mm,
    input  logic [7:0] load_ss,
    input  logic       load_pm,
    input  logic       alarm_wr,
    input  logic       alarm_on,
    input  logic       alarm_ack,
    output logic       pm,
    output logic [7:0] hh,
    output logic [7:0] mm,
    output logic [7:0] ss,
    output logic       sec_tick,
    output logic       alarm,
    output logic       load_err
);

    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);
    localparam logic [7:0]    HR_RESET   = H24 ? 8'h00 : HR12_MAX;

    logic [PW-1:0] presc_q;
    logic          tick;
    logic          adv;
    logic          load_valid;
    logic          load_ok;
    logic          wr_ok;
    logic          ss_carry;
    logic          mm_carry;
    logic [7:0]    hh_q;
    logic [7:0]    hh_next;
    logic          pm_q;
    logic          pm_next;
    logic          upd_q;
    logic          match;
    bcd_time_t     load_t;
    bcd_time_t     alarm_t;

    // The PM flag has no meaning in 24-hour builds, so it is forced low there.
    assign load_t     = {load_hh, load_mm, load_ss, (H24 ? 1'b0 : load_pm)};
    assign load_valid = is_valid_bcd_time(load_t, H24);
    assign load_ok    = load && load_valid;
    assign wr_ok      = alarm_wr && load_valid;

    // A valid load swallows the tick of the same cycle.
    assign tick = ena && (presc_q == PRESC_LAST);
    assign adv  = tick && !load_ok;

    // Seconds prescaler: counts enabled cycles, restarts on a valid load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            presc_q <= '0;
        else if (load_ok)
            presc_q <= '0;
        else if (ena)
            presc_q <= (presc_q == PRESC_LAST) ? '0 : presc_q + PW'(1);
    end

    bcd_mod_counter #(.MIN(8'h00), .MAX(SEC_MAX)) u_ss (
        .clk    (clk),
        .reset  (reset),
        .inc    (adv),
        .ld     (load_ok),
        .ld_val (load_ss),
        .val    (ss),
        .carry  (ss_carry)
    );

    bcd_mod_counter #(.MIN(8'h00), .MAX(MIN_MAX)) u_mm (
        .clk    (clk),
        .reset  (reset),
        .inc    (ss_carry),
        .ld     (load_ok),
        .ld_val (load_mm),
        .val    (mm),
        .carry  (mm_carry)
    );

    // Hour sequencing: 12,01..11,12 with PM flip at 11->12, or 00..23.
    always_comb begin
        hh_next = hh_q;
        pm_next = pm_q;
        if (load_ok) begin
            hh_next = load_hh;
            pm_next = load_t.pm;
        end else if (mm_carry) begin
            if (H24) begin
                hh_next = (hh_q == HR24_MAX) ? 8'h00 : bcd_inc(hh_q);
            end else if (hh_q == HR12_MAX) begin
                hh_next = HR12_MIN;
            end else begin
                hh_next = bcd_inc(hh_q);
                if (hh_q == 8'h11)
                    pm_next = ~pm_q;
            end
        end
    end

    // Hour and PM registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hh_q <= HR_RESET;
            pm_q <= 1'b0;
        end else begin
            hh_q <= hh_next;
            pm_q <= pm_next;
        end
    end

    assign hh = hh_q;
    // BCD ordering matches binary ordering, so a plain compare finds 12:00 and later.
    assign pm = H24 ? (hh_q >= HR12_MAX) : pm_q;

    // Alarm set-point registers, written only with a valid time.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            alarm_t <= {HR_RESET, 8'h00, 8'h00, 1'b0};
        else if (wr_ok)
            alarm_t <= load_t;
    end

    // The compare looks at the freshly updated time one cycle after the update.
    assign match = upd_q && alarm_on
                   && (hh_q == alarm_t.hh) && (mm == alarm_t.mm) && (ss == alarm_t.ss)
                   && (H24 || (pm_q == alarm_t.pm));

    // Status pulses, update marker and the sticky alarm (a match beats an ack).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sec_tick <= 1'b0;
            load_err <= 1'b0;
            upd_q    <= 1'b0;
            alarm    <= 1'b0;
        end else begin
            sec_tick <= adv;
            load_err <= (load || alarm_wr) && !load_valid;
            upd_q    <= adv || load_ok;
            alarm    <= match || (alarm && !alarm_ack);
        end
    end

endmodule

// File: tb/tb_bcd_clock_alarm.sv
// Directed bench: 12h/1-tick, 24h/1-tick and 12h/4-tick builds side by side.
module tb_bcd_clock_alarm;

    logic       clk;
    logic       reset;
    logic       ena;
    logic       load;
    logic [7:0] load_hh;
    logic [7:0] load_mm;
    logic [7:0] load_ss;
    logic       load_pm;
    logic       alarm_wr;
    logic       alarm_on;
    logic       alarm_ack;

    logic       a_pm, a_tick, a_alarm, a_err;
    logic [7:0] a_hh, a_mm, a_ss;
    logic       b_pm, b_tick, b_alarm, b_err;
    logic [7:0] b_hh, b_mm, b_ss;
    logic       c_pm, c_tick, c_alarm, c_err;
    logic [7:0] c_hh, c_mm, c_ss;

    int checks = 0;
    int errors = 0;

    bcd_clock_alarm #(.TICKS_PER_SEC(1), .H24(1'b0)) u12 (
        .clk(clk), .reset(reset), .ena(ena), .load(load),
        .load_hh(load_hh), .load_mm(load_mm), .load_ss(load_ss), .load_pm(load_pm),
        .alarm_wr(alarm_wr), .alarm_on(alarm_on), .alarm_ack(alarm_ack),
        .pm(a_pm), .hh(a_hh), .mm(a_mm), .ss(a_ss),
        .sec_tick(a_tick), .alarm(a_alarm), .load_err(a_err)
    );

    bcd_clock_alarm #(.TICKS_PER_SEC(1), .H24(1'b1)) u24 (
        .clk(clk), .reset(reset), .ena(ena), .load(load),
        .load_hh(load_hh), .load_mm(load_mm), .load_ss(load_ss), .load_pm(load_pm),
        .alarm_wr(alarm_wr), .alarm_on(alarm_on), .alarm_ack(alarm_ack),
        .pm(b_pm), .hh(b_hh), .mm(b_mm), .ss(b_ss),
        .sec_tick(b_tick), .alarm(b_alarm), .load_err(b_err)
    );

    bcd_clock_alarm #(.TICKS_PER_SEC(4), .H24(1'b0)) u4 (
        .clk(clk), .reset(reset), .ena(ena), .load(load),
        .load_hh(load_hh), .load_mm(load_mm), .load_ss(load_ss), .load_pm(load_pm),
        .alarm_wr(alarm_wr), .alarm_on(alarm_on), .alarm_ack(alarm_ack),
        .pm(c_pm), .hh(c_hh), .mm(c_mm), .ss(c_ss),
        .sec_tick(c_tick), .alarm(c_alarm), .load_err(c_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       ld;
        logic [7:0] lh, lm, ls;
        logic       lp;
        logic       en;
        logic [7:0] eh, em, es;
        logic       ep, et, ee;
    } vec_t;

    vec_t vt[16];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_load(input logic l, input logic [7:0] h, input logic [7:0] m,
                            input logic [7:0] s, input logic p);
        load    = l;
        load_hh = h;
        load_mm = m;
        load_ss = s;
        load_pm = p;
    endtask

    task automatic sync_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    int n;

    initial begin
        vt[0]  = '{1'b1, 8'h11, 8'h59, 8'h59, 1'b0, 1'b0, 8'h11, 8'h59, 8'h59, 1'b0, 1'b0, 1'b0};
        vt[1]  = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 8'h12, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0};
        vt[2]  = '{1'b1, 8'h12, 8'h59, 8'h59, 1'b1, 1'b0, 8'h12, 8'h59, 8'h59, 1'b1, 1'b0, 1'b0};
        vt[3]  = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 8'h01, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0};
        vt[4]  = '{1'b1, 8'h11, 8'h59, 8'h59, 1'b1, 1'b0, 8'h11, 8'h59, 8'h59, 1'b1, 1'b0, 1'b0};
        vt[5]  = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 8'h12, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0};
        vt[6]  = '{1'b1, 8'h13, 8'h00, 8'h00, 1'b0, 1'b0, 8'h12, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1};
        vt[7]  = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h12, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
        vt[8]  = '{1'b1, 8'h12, 8'h00, 8'h5A, 1'b0, 1'b1, 8'h12, 8'h00, 8'h01, 1'b0, 1'b1, 1'b1};
        vt[9]  = '{1'b1, 8'h09, 8'h30, 8'h00, 1'b0, 1'b1, 8'h09, 8'h30, 8'h00, 1'b0, 1'b0, 1'b0};
        vt[10] = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 8'h09, 8'h30, 8'h01, 1'b0, 1'b1, 1'b0};
        vt[11] = '{1'b1, 8'h10, 8'h59, 8'h59, 1'b0, 1'b0, 8'h10, 8'h59, 8'h59, 1'b0, 1'b0, 1'b0};
        vt[12] = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 8'h11, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0};
        vt[13] = '{1'b1, 8'h00, 8'h10, 8'h00, 1'b0, 1'b0, 8'h11, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1};
        vt[14] = '{1'b1, 8'h0A, 8'h10, 8'h00, 1'b0, 1'b0, 8'h11, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1};
        vt[15] = '{1'b1, 8'h09, 8'h60, 8'h00, 1'b0, 1'b1, 8'h11, 8'h00, 8'h01, 1'b0, 1'b1, 1'b1};

        reset = 1'b1;
        ena = 1'b0;
        alarm_wr = 1'b0;
        alarm_on = 1'b0;
        alarm_ack = 1'b0;
        set_load(1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
        step();
        step();
        reset = 1'b0;

        // Reset state of the 12h and 24h builds.
        chk("rst12 hh", a_hh, 8'h12);
        chk("rst12 mm", a_mm, 8'h00);
        chk("rst12 ss", a_ss, 8'h00);
        chk("rst12 pm", {7'd0, a_pm}, 8'h00);
        chk("rst12 tick", {7'd0, a_tick}, 8'h00);
        chk("rst12 alarm", {7'd0, a_alarm}, 8'h00);
        chk("rst12 err", {7'd0, a_err}, 8'h00);
        chk("rst24 hh", b_hh, 8'h00);
        chk("rst24 pm", {7'd0, b_pm}, 8'h00);

        // Table-driven 12-hour sequencing, invalid loads and load/tick priority.
        for (int i = 0; i < 16; i++) begin
            set_load(vt[i].ld, vt[i].lh, vt[i].lm, vt[i].ls, vt[i].lp);
            ena = vt[i].en;
            step();
            chk($sformatf("vec%0d hh", i), a_hh, vt[i].eh);
            chk($sformatf("vec%0d mm", i), a_mm, vt[i].em);
            chk($sformatf("vec%0d ss", i), a_ss, vt[i].es);
            chk($sformatf("vec%0d pm", i), {7'd0, a_pm}, {7'd0, vt[i].ep});
            chk($sformatf("vec%0d tick", i), {7'd0, a_tick}, {7'd0, vt[i].et});
            chk($sformatf("vec%0d err", i), {7'd0, a_err}, {7'd0, vt[i].ee});
        end
        set_load(1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
        ena = 1'b0;

        // 24-hour build: midnight rollover and 13h being legal only there.
        set_load(1'b1, 8'h23, 8'h59, 8'h59, 1'b1);
        step();
        chk("h24 load hh", b_hh, 8'h23);
        chk("h24 load pm", {7'd0, b_pm}, 8'h01);
        set_load(1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
        ena = 1'b1;
        step();
        ena = 1'b0;
        chk("h24 wrap hh", b_hh, 8'h00);
        chk("h24 wrap mm", b_mm, 8'h00);
        chk("h24 wrap ss", b_ss, 8'h00);
        chk("h24 wrap pm", {7'd0, b_pm}, 8'h00);
        chk("h24 wrap tick", {7'd0, b_tick}, 8'h01);
        set_load(1'b1, 8'h13, 8'h45, 8'h00, 1'b0);
        step();
        set_load(1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
        chk("h24 13h hh", b_hh, 8'h13);
        chk("h24 13h pm", {7'd0, b_pm}, 8'h01);
        chk("h24 13h err", {7'd0, b_err}, 8'h00);
        chk("h12 13h err", {7'd0, a_err}, 8'h01);

        // Four-cycle prescaler: 12 enabled cycles give 3 seconds, ena=0 freezes.
        sync_reset();
        ena = 1'b1;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (c_tick) n++;
        end
        chk("p4 ss after 12", c_ss, 8'h03);
        chk("p4 tick count", 8'(n), 8'd3);
        ena = 1'b0;
        n = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (c_tick) n++;
        end
        chk("p4 frozen ss", c_ss, 8'h03);
        chk("p4 frozen ticks", 8'(n), 8'd0);

        // Load on the tick cycle wins and restarts the prescaler.
        ena = 1'b1;
        step();
        step();
        step();
        chk("p4 pre-load ss", c_ss, 8'h03);
        set_load(1'b1, 8'h05, 8'h00, 8'h00, 1'b0);
        step();
        set_load(1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
        chk("p4 coincide hh", c_hh, 8'h05);
        chk("p4 coincide ss", c_ss, 8'h00);
        chk("p4 coincide tick", {7'd0, c_tick}, 8'h00);
        step();
        step();
        step();
        chk("p4 restart ss3", c_ss, 8'h00);
        step();
        chk("p4 restart ss4", c_ss, 8'h01);
        chk("p4 restart tick", {7'd0, c_tick}, 8'h01);
        ena = 1'b0;

        // Alarm at 12:00:05 after a fresh start.
        sync_reset();
        set_load(1'b0, 8'h12, 8'h00, 8'h05, 1'b0);
        alarm_wr = 1'b1;
        alarm_on = 1'b1;
        step();
        alarm_wr = 1'b0;
        chk("alm wr keeps ss", a_ss, 8'h00);
        chk("alm wr err", {7'd0, a_err}, 8'h00);
        ena = 1'b1;
        for (int i = 0; i < 5; i++) step();
        ena = 1'b0;
        chk("alm time ss", a_ss, 8'h05);
        chk("alm not yet", {7'd0, a_alarm}, 8'h00);
        step();
        chk("alm set", {7'd0, a_alarm}, 8'h01);
        step();
        chk("alm sticky", {7'd0, a_alarm}, 8'h01);
        alarm_ack = 1'b1;
        step();
        alarm_ack = 1'b0;
        chk("alm acked", {7'd0, a_alarm}, 8'h00);

        // alarm_on=0 blocks a matching time.
        alarm_on = 1'b0;
        set_load(1'b1, 8'h12, 8'h00, 8'h05, 1'b0);
        step();
        set_load(1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
        step();
        step();
        chk("alm off blocks", {7'd0, a_alarm}, 8'h00);

        // Invalid alarm write pulses load_err for one cycle.
        set_load(1'b0, 8'h13, 8'h00, 8'h00, 1'b0);
        alarm_wr = 1'b1;
        step();
        alarm_wr = 1'b0;
        chk("alm bad wr err", {7'd0, a_err}, 8'h01);
        step();
        chk("alm bad wr err clr", {7'd0, a_err}, 8'h00);

        // Re-arm via a matching load; the set-point survived the bad write.
        alarm_on = 1'b1;
        set_load(1'b1, 8'h12, 8'h00, 8'h05, 1'b0);
        step();
        set_load(1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
        step();
        chk("alm load match", {7'd0, a_alarm}, 8'h01);

        // Ack in the same cycle as a new match: the match wins.
        set_load(1'b1, 8'h12, 8'h00, 8'h05, 1'b0);
        step();
        set_load(1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
        alarm_ack = 1'b1;
        step();
        alarm_ack = 1'b0;
        chk("alm match beats ack", {7'd0, a_alarm}, 8'h01);

        // Asynchronous reset in the middle of a clock period.
        ena = 1'b1;
        step();
        step();
        chk("arst pre ss", a_ss, 8'h07);
        #3;
        reset = 1'b1;
        #1;
        chk("arst hh", a_hh, 8'h12);
        chk("arst mm", a_mm, 8'h00);
        chk("arst ss", a_ss, 8'h00);
        chk("arst pm", {7'd0, a_pm}, 8'h00);
        chk("arst alarm", {7'd0, a_alarm}, 8'h00);
        chk("arst h24 hh", b_hh, 8'h00);
        chk("arst p4 hh", c_hh, 8'h12);
        step();
        reset = 1'b0;
        step();
        step();
        step();
        chk("arst p4 presc ss3", c_ss, 8'h00);
        step();
        chk("arst p4 presc ss4", c_ss, 8'h01);
        ena = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
